// File: rtl/cam_ctrl_if.sv
// Request/response and status bundle between the command logic (master)
// and the CAM sequencing controller (slave).
interface cam_ctrl_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [DATA_WIDTH-1:0] req_key;
  logic                  rsp_valid;
  logic                  rsp_hit;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_err;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;

  modport master (
    output req_valid, req_op, req_key,
    input  req_ready, rsp_valid, rsp_hit, rsp_addr, rsp_err, count, full
  );

  modport slave (
    input  req_valid, req_op, req_key,
    output req_ready, rsp_valid, rsp_hit, rsp_addr, rsp_err, count, full
  );
endinterface

// File: rtl/cam_ctrl.sv
// Sequencing controller for the RAM-based CAM array: lookup, insert with
// duplicate rejection and sequential allocation, and clear-all.
module cam_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  cam_ctrl_if.slave                    ctrl,
  output logic                         cam_rst,
  output logic                         cam_write,
  output logic [ADDR_WIDTH-1:0]        cam_a_addr,
  output logic [DATA_WIDTH-1:0]        cam_a_din,
  output logic [DATA_WIDTH-1:0]        cam_b_din,
  input  logic [(1<<ADDR_WIDTH)-1:0]   cam_match
);
  localparam int ENTRIES = 1 << ADDR_WIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_CLEAR  = 2'd3;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  logic [1:0]            r_state;
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_key;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_rsp_valid;
  logic                  r_rsp_hit;
  logic [ADDR_WIDTH-1:0] r_rsp_addr;
  logic                  r_rsp_err;
  logic                  r_cam_rst;
  logic                  r_cam_write;
  logic [ADDR_WIDTH-1:0] r_cam_a_addr;
  logic [DATA_WIDTH-1:0] r_cam_a_din;
  logic [DATA_WIDTH-1:0] r_cam_b_din;

  logic                  w_hit;
  logic                  w_full;
  logic [ADDR_WIDTH-1:0] w_enc_addr;

  assign w_hit  = |cam_match;
  assign w_full = (r_count == (ADDR_WIDTH+1)'(ENTRIES));

  // Scan from the top down so the lowest matching index is the last assignment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_enc_addr = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (cam_match[i]) w_enc_addr = ADDR_WIDTH'(i);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= OP_LOOKUP;
      r_key        <= '0;
      r_count      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_hit    <= 1'b0;
      r_rsp_addr   <= '0;
      r_rsp_err    <= 1'b0;
      r_cam_rst    <= 1'b1;
      r_cam_write  <= 1'b0;
      r_cam_a_addr <= '0;
      r_cam_a_din  <= '0;
      r_cam_b_din  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_cam_rst   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ctrl.req_valid) begin
            case (ctrl.req_op)
              OP_LOOKUP, OP_INSERT: begin
                r_cam_b_din <= ctrl.req_key;
                r_op        <= ctrl.req_op;
                r_key       <= ctrl.req_key;
                r_state     <= S_SEARCH;
              end
              OP_CLEAR: begin
                r_cam_rst <= 1'b1;
                r_state   <= S_CLEAR;
              end
              default: begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_hit   <= 1'b0;
              end
            endcase
          end
        end
        S_SEARCH: begin
          // cam_match now reflects the key registered on the accept edge.
          if (r_op == OP_INSERT && !w_hit && !w_full) begin
            r_cam_write  <= 1'b1;
            r_cam_a_addr <= r_count[ADDR_WIDTH-1:0];
            r_cam_a_din  <= r_key;
            r_state      <= S_WRITE;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= w_hit;
            r_rsp_addr  <= w_hit ? w_enc_addr : '0;
            r_rsp_err   <= (r_op == OP_INSERT) && !w_hit;
            r_state     <= S_IDLE;
          end
        end
        S_WRITE: begin
          r_cam_write <= 1'b0;
          r_count     <= r_count + 1'b1;
          r_rsp_valid <= 1'b1;
          r_rsp_hit   <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_addr  <= r_cam_a_addr;
          r_state     <= S_IDLE;
        end
        S_CLEAR: begin
          r_count     <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_hit   <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ctrl.req_ready = (r_state == S_IDLE) && !rst;
  assign ctrl.rsp_valid = r_rsp_valid;
  assign ctrl.rsp_hit   = r_rsp_hit;
  assign ctrl.rsp_addr  = r_rsp_addr;
  assign ctrl.rsp_err   = r_rsp_err;
  assign ctrl.count     = r_count;
  assign ctrl.full      = w_full;

  assign cam_rst    = r_cam_rst;
  assign cam_write  = r_cam_write;
  assign cam_a_addr = r_cam_a_addr;
  assign cam_a_din  = r_cam_a_din;
  assign cam_b_din  = r_cam_b_din;
endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Sequencing controller for the RAM-based CAM array (ram_dp).
- Accepts single-request commands (lookup, insert, clear-all) over a valid/ready interface.
- Drives the array's write/address/key/reset ports and priority-encodes the array's match vector into a hit flag and address.
- Allocates entry addresses sequentially, rejects duplicate keys, and reports a full condition.
- Sits between the Pass-Keeper command logic and the CAM array.

Parameters:
- DATA_WIDTH, 4: key width; must equal the array's DATA_WIDTH.
- ADDR_WIDTH, 4: entry address width; ENTRIES = 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock; controller logic on rising edge (array samples on falling edge).
- rst  in  1  reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  00 lookup, 01 insert, 10 clear, 11 reserved.
- req_key  in  DATA_WIDTH  key for lookup/insert.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_hit  out  1  key found (lookup), or key already present (insert).
- rsp_addr  out  ADDR_WIDTH  matching address, or newly written address.
- rsp_err  out  1  insert into full table, or reserved op.
- count  out  ADDR_WIDTH+1  number of valid entries.
- full  out  1  count == ENTRIES.
- cam_rst  out  1  to array rst.
- cam_write  out  1  to array write.
- cam_a_addr  out  ADDR_WIDTH  to array a_addr.
- cam_a_din  out  DATA_WIDTH  to array a_din.
- cam_b_din  out  DATA_WIDTH  to array b_din.
- cam_match  in  ENTRIES  from array b_dout.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, count 0, rsp_valid/rsp_hit/rsp_err 0, rsp_addr 0, cam_write 0, cam_a_addr/cam_a_din/cam_b_din 0.
- During reset, cam_rst is registered to 1, so the array clears on the following falling edge. cam_rst returns to 0 on the first rising edge with rst low.
- req_ready = (state==IDLE) && !rst. A request is accepted on a rising edge with req_valid && req_ready.
- All outputs are registered except req_ready and full.
- States: IDLE, SEARCH, WRITE, CLEAR.
- IDLE, on accept:
  - op 00/01: cam_b_din <= req_key, latch op and key, go to SEARCH.
  - op 10: cam_rst <= 1, go to CLEAR.
  - op 11: rsp_valid <= 1, rsp_err <= 1, rsp_hit <= 0, stay in IDLE. The array is not touched.
- Array timing: the key registered at edge E0 is looked up on the falling edge within cycle E0..E1. cam_match is stable and sampled at E1.
- SEARCH (edge E1):
  - Priority-encode cam_match; the lowest set index wins.
  - Lookup: rsp_valid <= 1, rsp_hit <= |cam_match, rsp_addr <= encoded index (0 on miss), go to IDLE. Lookup latency: response visible 1 cycle after accept.
  - Insert, hit: respond rsp_hit=1 with the existing address. No write, count unchanged, go to IDLE.
  - Insert, miss and full: respond rsp_err=1, rsp_hit=0, rsp_addr=0, go to IDLE.
  - Insert, miss and not full: cam_write <= 1, cam_a_addr <= count[ADDR_WIDTH-1:0], cam_a_din <= key, go to WRITE.
- WRITE (edge E2):
  - The array commits the bit on the falling edge before E2.
  - cam_write <= 0, count <= count+1, rsp_valid <= 1, rsp_hit <= 0, rsp_addr <= address written, go to IDLE.
  - Insert latency: 2 cycles after accept.
- CLEAR (edge E1):
  - The array clears on the falling edge in between.
  - cam_rst <= 0, count <= 0, rsp_valid <= 1 with hit=0 and err=0, go to IDLE.
- rsp_valid is high for exactly one cycle per accepted request; other rsp fields hold until the next response.
- A request accepted on the same edge that rsp_valid rises is legal. Back-to-back lookup-after-insert returns the new entry, because the write commits before the next key is registered.
- Entries are never individually deleted. Allocation is always address = count; no wrap-around. count saturates at ENTRIES via the full check.
- Reset in any state aborts the operation with no response: cam_write drops, count returns to 0, and the array is cleared.

Test Plan:
1. Reset, then lookup key 0x5 -> 1 cycle after accept: rsp_valid=1, rsp_hit=0, rsp_addr=0; count=0.
2. Insert 0x5, then insert 0xA -> responses addr 0 then addr 1, 2 cycles after each accept; count=2. Lookup 0xA -> hit=1, addr=1.
3. Insert 0x5 again -> rsp_hit=1, addr=0, no cam_write pulse, count stays 2.
4. With ADDR_WIDTH=2: insert 0x1, 0x2, 0x3, 0x4 -> full=1. Insert 0x6 -> rsp_err=1, no write. Reserved op 11 -> rsp_err=1 the cycle after accept.
5. Clear after inserts -> cam_rst pulses 1 cycle, rsp_valid next cycle, count=0. Lookup 0x5 -> hit=0.
6. Assert rst on the edge where state=WRITE -> no rsp_valid, count=0, req_ready=1 after rst falls, previously inserted keys miss.
